hash_sequencer: RTL and testbench

//  Sequences one LFSR/bent-function hash core, i.e. lfsr_in feeding bent functions into lfsr_out.

---
 rtl/hash_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_hash_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_sequencer.sv
// Sequencer for an LFSR/bent-function hash core: serialises message words MSB-first
// onto the core injector bit, appends zero flush cycles and captures the digest.
module hash_sequencer #(
    parameter int unsigned WORD_W       = 32,
    parameter int unsigned OUT_W        = 64,
    parameter int unsigned FLUSH_CYCLES = 128,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              msg_valid,
    output logic              msg_ready,
    input  logic [WORD_W-1:0] msg_data,
    input  logic              msg_last,
    output logic              hash_rst,
    output logic              hash_inject,
    input  logic [OUT_W-1:0]  hash_o,
    output logic              digest_valid,
    input  logic              digest_ready,
    output logic [OUT_W-1:0]  digest,
    output logic [CNT_W-1:0]  bit_count,
    output logic              gap_err,
    output logic              busy
);
    localparam int unsigned BIT_W = $clog2(WORD_W);
    localparam int unsigned FL_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(WORD_W - 1);
    localparam logic [FL_W-1:0]  FLUSH_LOAD = FL_W'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ABSORB,
        S_SHIFT,
        S_GAP,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]  bitidx_q, bitidx_d;
    logic              last_q, last_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic              hold_last_q, hold_last_d;
    logic              last_acc_q, last_acc_d;
    logic [FL_W-1:0]   flush_q, flush_d;
    logic [OUT_W-1:0]  digest_q, digest_d;
    logic [CNT_W-1:0]  bit_count_q, bit_count_d;
    logic              gap_err_q, gap_err_d;
    logic              accept;

    always_comb begin
        msg_ready = 1'b0;
        case (state_q)
            S_ABSORB, S_GAP: msg_ready = 1'b1;
            S_SHIFT:         msg_ready = !hold_valid_q && !last_acc_q;
            default:         msg_ready = 1'b0;
        endcase
        if (abort) msg_ready = 1'b0;
    end

    assign accept = msg_valid && msg_ready;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bitidx_d     = bitidx_q;
        last_d       = last_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        hold_last_d  = hold_last_q;
        last_acc_d   = last_acc_q;
        flush_d      = flush_q;
        digest_d     = digest_q;
        bit_count_d  = bit_count_q;
        gap_err_d    = gap_err_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                bit_count_d  = '0;
                gap_err_d    = 1'b0;
                hold_valid_d = 1'b0;
                last_acc_d   = 1'b0;
                state_d      = S_ABSORB;
            end
            S_ABSORB, S_GAP: begin
                if (state_q == S_GAP) gap_err_d = 1'b1;
                if (accept) begin
                    shreg_d  = msg_data;
                    bitidx_d = LAST_BIT;
                    last_d   = msg_last;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_count_q != '1) bit_count_d = bit_count_q + 1'b1;
                shreg_d  = {shreg_q[WORD_W-2:0], 1'b0};
                bitidx_d = bitidx_q - 1'b1;
                // On the final bit the next word (held or arriving now) replaces shreg without a gap
                if (bitidx_q == '0) begin
                    if (hold_valid_q) begin
                        shreg_d      = hold_q;
                        bitidx_d     = LAST_BIT;
                        last_d       = hold_last_q;
                        hold_valid_d = 1'b0;
                    end else if (accept) begin
                        shreg_d  = msg_data;
                        bitidx_d = LAST_BIT;
                        last_d   = msg_last;
                    end else if (last_q) begin
                        flush_d = FLUSH_LOAD;
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_GAP;
                    end
                end else if (accept) begin
                    hold_d       = msg_data;
                    hold_last_d  = msg_last;
                    hold_valid_d = 1'b1;
                end
            end
            S_FLUSH: begin
                if (flush_q == '0) begin
                    digest_d = hash_o;
                    state_d  = S_DONE;
                end else begin
                    flush_d = flush_q - 1'b1;
                end
            end
            S_DONE: begin
                if (digest_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept && msg_last) last_acc_d = 1'b1;

        if (abort) begin
            state_d      = S_IDLE;
            hold_valid_d = 1'b0;
            last_acc_d   = 1'b0;
            last_d       = 1'b0;
            digest_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bitidx_q     <= '0;
            last_q       <= 1'b0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_last_q  <= 1'b0;
            last_acc_q   <= 1'b0;
            flush_q      <= '0;
            digest_q     <= '0;
            bit_count_q  <= '0;
            gap_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bitidx_q     <= bitidx_d;
            last_q       <= last_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            hold_last_q  <= hold_last_d;
            last_acc_q   <= last_acc_d;
            flush_q      <= flush_d;
            digest_q     <= digest_d;
            bit_count_q  <= bit_count_d;
            gap_err_q    <= gap_err_d;
        end
    end

    assign hash_rst     = reset | (state_q == S_CLEAR) | abort;
    assign hash_inject  = (state_q == S_SHIFT) & shreg_q[WORD_W-1];
    assign digest_valid = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE);
    assign digest       = digest_q;
    assign bit_count    = bit_count_q;
    assign gap_err      = gap_err_q;
endmodule

// File: tb/tb_hash_sequencer.sv
// Scoreboard bench for hash_sequencer with a small LFSR/bent-function core model
// driving hash_o; expected digests come from folding the scheduled bit stream.
module tb_hash_sequencer;
    localparam int unsigned WORD_W       = 8;
    localparam int unsigned OUT_W        = 16;
    localparam int unsigned FLUSH_CYCLES = 4;
    localparam int unsigned CNT_W        = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              msg_valid = 1'b0;
    logic              msg_ready;
    logic [WORD_W-1:0] msg_data = '0;
    logic              msg_last = 1'b0;
    logic              hash_rst;
    logic              hash_inject;
    logic [OUT_W-1:0]  hash_o;
    logic              digest_valid;
    logic              digest_ready = 1'b0;
    logic [OUT_W-1:0]  digest;
    logic [CNT_W-1:0]  bit_count;
    logic              gap_err;
    logic              busy;

    hash_sequencer #(
        .WORD_W(WORD_W), .OUT_W(OUT_W), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data), .msg_last(msg_last),
        .hash_rst(hash_rst), .hash_inject(hash_inject), .hash_o(hash_o),
        .digest_valid(digest_valid), .digest_ready(digest_ready), .digest(digest),
        .bit_count(bit_count), .gap_err(gap_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core: 16-bit input LFSR with injector, bent function of it feeding a 16-bit output LFSR.
    function automatic logic [31:0] core_step(input logic [31:0] st, input logic b);
        logic [15:0] li, lo;
        logic fb, bent;
        li   = st[31:16];
        lo   = st[15:0];
        bent = (li[1] & li[6]) ^ (li[3] & li[9]) ^ (li[11] & li[14]);
        fb   = li[15] ^ li[13] ^ li[12] ^ li[10] ^ b;
        return {li[14:0], fb, lo[14:0], lo[15] ^ lo[4] ^ bent};
    endfunction

    logic [31:0] core_q;
    always @(posedge clk) core_q <= hash_rst ? 32'd0 : core_step(core_q, hash_inject);
    assign hash_o = core_q[15:0];

    logic inj_rec [0:4095];
    logic rst_rec [0:4095];
    always @(negedge clk) begin
        inj_rec[cyc[11:0]] <= hash_inject;
        rst_rec[cyc[11:0]] <= hash_rst;
    end

    typedef struct {
        logic [15:0] dig;
        logic [31:0] bc;
        logic        ge;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  words_q[$];
    int unsigned dly_q[$];
    int          errors = 0;
    int          checks = 0;
    int          mon_state = 0;
    int unsigned rdy_hold = 0;
    int unsigned held = 0;
    int          spurious = 0;
    logic [15:0] cap;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bail(input string name);
        errors++;
        checks++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int unsigned t = 0;
        forever begin
            @(negedge clk);
            if (sb.size() == 0 && mon_state == 0 && !busy) break;
            t++;
            if (t > 400) bail("wait_idle_timeout");
        end
        step();
    endtask

    // Sends words_q with per-word idle delays dly_q, then predicts the digest from the bit schedule.
    task automatic send_msg(input int unsigned rdy, input bit poke);
        int unsigned s, b0, nxt, bk, t, n, idx, nbad;
        int unsigned v[$];
        logic        bits[$];
        logic        full[$];
        logic [31:0] st;
        logic        ge;
        logic        acc;
        exp_t        e;
        rdy_hold = rdy;
        n = words_q.size();
        s = cyc;
        start = 1'b1;
        for (int k = 0; k < int'(n); k++) begin
            for (int unsigned d = 0; d < dly_q[k]; d++) begin
                step();
                start = 1'b0;
            end
            msg_valid = 1'b1;
            msg_data  = words_q[k];
            msg_last  = (k == int'(n) - 1);
            v.push_back(cyc);
            t = 0;
            forever begin
                @(negedge clk);
                acc = msg_ready;
                step();
                start = 1'b0;
                if (acc) break;
                t++;
                if (t > 300) bail("handshake_timeout");
            end
            msg_valid = 1'b0;
            msg_last  = 1'b0;
        end

        nxt = s + 3;
        ge  = 1'b0;
        b0  = 0;
        for (int k = 0; k < int'(n); k++) begin
            bk = (v[k] + 1 > nxt) ? v[k] + 1 : nxt;
            if (k == 0) b0 = bk;
            else begin
                if (bk > nxt) ge = 1'b1;
                for (int unsigned g = nxt; g < bk; g++) bits.push_back(1'b0);
            end
            for (int i = 7; i >= 0; i--) bits.push_back(words_q[k][i]);
            nxt = bk + 8;
        end
        st = '0;
        foreach (bits[i]) st = core_step(st, bits[i]);
        for (int unsigned i = 1; i < FLUSH_CYCLES; i++) st = core_step(st, 1'b0);
        e.dig = st[15:0];
        e.bc  = 32'(8 * n);
        e.ge  = ge;
        e.cyc = nxt - 1 + FLUSH_CYCLES + 1;
        sb.push_back(e);

        if (poke) begin
            t = 0;
            forever begin
                @(negedge clk);
                if (mon_state == 1) break;
                t++;
                if (t > 300) bail("done_wait_timeout");
            end
            step();
            start = 1'b1;
            msg_valid = 1'b1;
            msg_data = 8'h3C;
            step();
            start = 1'b0;
            msg_valid = 1'b0;
        end
        wait_idle();

        for (int unsigned z = s + 2; z < b0; z++) full.push_back(1'b0);
        foreach (bits[i]) full.push_back(bits[i]);
        for (int unsigned i = 0; i < FLUSH_CYCLES; i++) full.push_back(1'b0);
        nbad = 0;
        foreach (full[i]) begin
            idx = s + 2 + i;
            if (inj_rec[idx[11:0]] !== full[i]) nbad++;
        end
        chk("inject_stream_mismatches", 64'(nbad), 64'd0);
        idx = s;
        chk("hash_rst_pulse", {61'd0, rst_rec[idx[11:0]], rst_rec[idx[11:0] + 12'd1],
            rst_rec[idx[11:0] + 12'd2]}, 64'b010);
    endtask

    task automatic one_word(input logic [7:0] w, input int unsigned dly);
        words_q.delete();
        dly_q.delete();
        words_q.push_back(w);
        dly_q.push_back(dly);
    endtask

    task automatic two_words(input logic [7:0] w0, input logic [7:0] w1, input int unsigned d1);
        one_word(w0, 0);
        words_q.push_back(w1);
        dly_q.push_back(d1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (!reset) begin
                        case (mon_state)
                            0: if (digest_valid) begin
                                if (sb.size() == 0) begin
                                    spurious++;
                                    chk("unexpected_digest_valid", 64'd1, 64'd0);
                                end else begin
                                    e = sb.pop_front();
                                    chk("digest", 64'(digest), 64'(e.dig));
                                    chk("bit_count", 64'(bit_count), 64'(e.bc));
                                    chk("gap_err", 64'(gap_err), 64'(e.ge));
                                    chk("digest_latency_cycle", 64'(cyc), 64'(e.cyc));
                                end
                                cap  = digest;
                                held = 0;
                                if (rdy_hold == 0) begin
                                    digest_ready = 1'b1;
                                    mon_state = 2;
                                end else begin
                                    mon_state = 1;
                                end
                            end
                            1: begin
                                held++;
                                chk("done_hold_{valid,busy,ready,digest}",
                                    64'({digest_valid, busy, msg_ready, digest}), 64'({3'b110, cap}));
                                if (held >= rdy_hold) begin
                                    digest_ready = 1'b1;
                                    mon_state = 2;
                                end
                            end
                            default: begin
                                digest_ready = 1'b0;
                                chk("after_consume_{valid,busy}", 64'({digest_valid, busy}), 64'd0);
                                mon_state = 0;
                            end
                        endcase
                    end
                end
            end
            begin : driver
                int unsigned n;
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("reset_hash_rst", 64'(hash_rst), 64'd1);
                chk("reset_msg_ready", 64'(msg_ready), 64'd0);
                chk("reset_digest_valid", 64'(digest_valid), 64'd0);
                chk("reset_busy", 64'(busy), 64'd0);
                chk("reset_digest", 64'(digest), 64'd0);
                chk("reset_bit_count_gap_err", 64'({bit_count, gap_err}), 64'd0);
                step();
                reset = 1'b0;
                step();

                one_word(8'hA5, 0);
                send_msg(0, 1'b0);
                two_words(8'hFF, 8'h00, 0);
                send_msg(1, 1'b0);
                two_words(8'h81, 8'h7E, 10);
                send_msg(0, 1'b0);

                start = 1'b1;
                msg_valid = 1'b1;
                msg_data = 8'hA5;
                msg_last = 1'b1;
                step();
                start = 1'b0;
                step();
                @(negedge clk);
                chk("abort_case_absorb_ready", 64'(msg_ready), 64'd1);
                step();
                msg_valid = 1'b0;
                msg_last = 1'b0;
                repeat (3) step();
                abort = 1'b1;
                @(negedge clk);
                chk("abort_hash_rst", 64'(hash_rst), 64'd1);
                step();
                abort = 1'b0;
                @(negedge clk);
                chk("abort_busy_next", 64'({busy, digest_valid}), 64'd0);
                repeat (20) step();
                chk("abort_no_digest", 64'({spurious, 1'b0} | 64'(digest_valid)), 64'd0);

                one_word(8'hA5, 0);
                send_msg(0, 1'b0);
                two_words(8'h5A, 8'hC3, 0);
                send_msg(10, 1'b1);

                for (int m = 0; m < 20; m++) begin
                    words_q.delete();
                    dly_q.delete();
                    n = $urandom_range(1, 4);
                    for (int unsigned k = 0; k < n; k++) begin
                        words_q.push_back(8'($urandom));
                        dly_q.push_back(($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 0);
                    end
                    send_msg($urandom_range(0, 3), 1'b0);
                end

                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        join
    end
endmodule
